// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, reads a synchronous-read instruction memory
// and hands instructions to decode through a 2-entry FIFO with valid/ready.
// Optional build macro: JUMP_PREDECODE_EN (J words redirect fetch on capture).
// Ports:
//   clock, reset                       rising-edge clock, async active-high reset
//   mem_address / mem_q                word address out, read data in (1-edge latency)
//   instr_valid / instr_ready          decode handshake
//   instr / instr_pc                   head-of-queue word and its word address
//   redirect_valid / redirect_target   one-cycle fetch restart request
module instruction_fetch #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target
);

    // RUN: a read was issued at the last edge, so its word is on mem_q now.
    // HOLD: issue was blocked by the credit check, nothing in flight.
    // RESTART: first cycle after a redirect, nothing in flight.
    typedef enum logic [1:0] {
        S_RUN,
        S_HOLD,
        S_RESTART
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;

    // Queue slot 0 is the head and directly drives the decode outputs.
    logic                  r_q0_vld;
    logic [DATA_WIDTH-1:0] r_q0_dat;
    logic [ADDR_WIDTH-1:0] r_q0_pc;
    logic                  r_q1_vld;
    logic [DATA_WIDTH-1:0] r_q1_dat;
    logic [ADDR_WIDTH-1:0] r_q1_pc;

    logic                  w_inflight;
    logic                  w_pop;
    logic [1:0]            w_occ;
    logic [2:0]            w_used;
    logic                  w_issue;
    logic                  w_jump;
    logic [ADDR_WIDTH-1:0] w_jump_tgt;

    logic                  w_n0_vld;
    logic [DATA_WIDTH-1:0] w_n0_dat;
    logic [ADDR_WIDTH-1:0] w_n0_pc;
    logic                  w_n1_vld;
    logic [DATA_WIDTH-1:0] w_n1_dat;
    logic [ADDR_WIDTH-1:0] w_n1_pc;

    assign mem_address = r_pc;
    assign instr_valid = r_q0_vld;
    assign instr       = r_q0_dat;
    assign instr_pc    = r_q0_pc;

    assign w_inflight = (r_state == S_RUN);
    assign w_pop      = r_q0_vld && instr_ready;
    assign w_occ      = {1'b0, r_q0_vld} + {1'b0, r_q1_vld};

    // Slots that will be committed after this edge if we issue now;
    // never underflows because a pop implies occupancy of at least 1.
    assign w_used  = {1'b0, w_occ} + {2'b0, w_inflight} - {2'b0, w_pop};
    assign w_issue = (w_used < 3'd2);

`ifdef JUMP_PREDECODE_EN
    assign w_jump     = w_inflight && (mem_q[31:26] == 6'b000010);
    assign w_jump_tgt = mem_q[ADDR_WIDTH-1:0];
`else
    assign w_jump     = 1'b0;
    assign w_jump_tgt = r_pc;
`endif

    // Next queue contents: shift on pop, then append the returning word
    // in the first free slot. The credit check keeps a slot free for it.
    always_comb begin
        w_n0_vld = r_q0_vld;
        w_n0_dat = r_q0_dat;
        w_n0_pc  = r_q0_pc;
        w_n1_vld = r_q1_vld;
        w_n1_dat = r_q1_dat;
        w_n1_pc  = r_q1_pc;
        if (w_pop) begin
            w_n0_vld = r_q1_vld;
            w_n0_dat = r_q1_dat;
            w_n0_pc  = r_q1_pc;
            w_n1_vld = 1'b0;
        end
        if (w_inflight) begin
            if (!w_n0_vld) begin
                w_n0_vld = 1'b1;
                w_n0_dat = mem_q;
                w_n0_pc  = r_inflight_pc;
            end else begin
                w_n1_vld = 1'b1;
                w_n1_dat = mem_q;
                w_n1_pc  = r_inflight_pc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_RESTART;
            r_pc          <= RESET_PC;
            r_inflight_pc <= '0;
            r_q0_vld      <= 1'b0;
            r_q0_dat      <= '0;
            r_q0_pc       <= '0;
            r_q1_vld      <= 1'b0;
            r_q1_dat      <= '0;
            r_q1_pc       <= '0;
        end else if (redirect_valid) begin
            // Flush: the word returning next cycle is dropped because
            // nothing is marked in flight.
            r_state  <= S_RESTART;
            r_pc     <= redirect_target;
            r_q0_vld <= 1'b0;
            r_q1_vld <= 1'b0;
        end else begin
            r_q0_vld <= w_n0_vld;
            r_q0_dat <= w_n0_dat;
            r_q0_pc  <= w_n0_pc;
            r_q1_vld <= w_n1_vld;
            r_q1_dat <= w_n1_dat;
            r_q1_pc  <= w_n1_pc;
            if (w_jump) begin
                // The J word is kept; the sequential read is not issued.
                r_state <= S_RESTART;
                r_pc    <= w_jump_tgt;
            end else if (w_issue) begin
                r_state       <= S_RUN;
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + ADDR_WIDTH'(1);
            end else begin
                r_state <= S_HOLD;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: vector table, directed corner sequences and a
// random scoreboard run for instruction_fetch.
module tb_instruction_fetch;

    logic        clock;
    logic        reset;
    logic [7:0]  mem_address;
    logic [31:0] mem_q;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_target;

    int errors;
    int checks;

    logic [31:0] mem [256];

    instruction_fetch #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .RESET_PC   (8'd0)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_q           (mem_q),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial mem_q = 32'h0;
    always @(posedge clock) mem_q <= mem[mem_address];

    typedef struct {
        logic        rdy;
        logic        ev;
        logic [7:0]  epc;
        logic [31:0] ei;
        logic [7:0]  ea;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 8'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string name, input logic ev,
                           input logic [7:0] epc, input logic [31:0] ei);
        chk({name, ".valid"}, {31'd0, instr_valid}, {31'd0, ev});
        if (ev) begin
            chk({name, ".pc"}, {24'd0, instr_pc}, {24'd0, epc});
            chk({name, ".instr"}, instr, ei);
        end
    endtask

    function automatic logic [7:0] next_pc(input logic [7:0] p);
        logic [31:0] w;
        w = mem[p];
`ifdef JUMP_PREDECODE_EN
        if (w[31:26] == 6'b000010) return w[7:0];
`endif
        return p + 8'd1;
    endfunction

    initial begin
        logic [7:0] exp_pc;
        int         pops;
        logic       pop;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h8C0100FF;
        mem[1] = 32'hAC010009;
        mem[2] = 32'h8C020009;
        mem[3] = 32'hAC0200FF;
        mem[4] = 32'h08000000;

        // Startup, throughput, 5-cycle backpressure on pc 1, end of program.
        tbl[0]  = '{1'b1, 1'b0, 8'd0, 32'h00000000, 8'd1};
        tbl[1]  = '{1'b1, 1'b1, 8'd0, 32'h8C0100FF, 8'd2};
        tbl[2]  = '{1'b1, 1'b1, 8'd1, 32'hAC010009, 8'd3};
        tbl[3]  = '{1'b0, 1'b1, 8'd1, 32'hAC010009, 8'd3};
        tbl[4]  = '{1'b0, 1'b1, 8'd1, 32'hAC010009, 8'd3};
        tbl[5]  = '{1'b0, 1'b1, 8'd1, 32'hAC010009, 8'd3};
        tbl[6]  = '{1'b0, 1'b1, 8'd1, 32'hAC010009, 8'd3};
        tbl[7]  = '{1'b0, 1'b1, 8'd1, 32'hAC010009, 8'd3};
        tbl[8]  = '{1'b1, 1'b1, 8'd2, 32'h8C020009, 8'd4};
        tbl[9]  = '{1'b1, 1'b1, 8'd3, 32'hAC0200FF, 8'd5};
`ifdef JUMP_PREDECODE_EN
        tbl[10] = '{1'b1, 1'b1, 8'd4, 32'h08000000, 8'd0};
        tbl[11] = '{1'b1, 1'b0, 8'd0, 32'h00000000, 8'd1};
        tbl[12] = '{1'b1, 1'b1, 8'd0, 32'h8C0100FF, 8'd2};
`else
        tbl[10] = '{1'b1, 1'b1, 8'd4, 32'h08000000, 8'd6};
        tbl[11] = '{1'b1, 1'b1, 8'd5, 32'h00000000, 8'd7};
        tbl[12] = '{1'b1, 1'b1, 8'd6, 32'h00000000, 8'd8};
`endif

        do_reset();
        chk_out("reset", 1'b0, 8'd0, 32'h0);
        chk("reset.instr", instr, 32'h0);
        chk("reset.pc", {24'd0, instr_pc}, 32'h0);
        chk("reset.addr", {24'd0, mem_address}, 32'h0);
        for (int i = 0; i < 13; i++) begin
            instr_ready = tbl[i].rdy;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].ei);
            chk($sformatf("vec%0d.addr", i), {24'd0, mem_address},
                {24'd0, tbl[i].ea});
        end

        // Full queue, then redirect to 3: stale entries must vanish.
        do_reset();
        repeat (4) step();
        chk_out("full", 1'b1, 8'd0, 32'h8C0100FF);
        redirect_valid  = 1'b1;
        redirect_target = 8'd3;
        step();
        redirect_valid = 1'b0;
        chk_out("rd3.e0", 1'b0, 8'd0, 32'h0);
        chk("rd3.e0.addr", {24'd0, mem_address}, 32'd3);
        step();
        chk_out("rd3.e1", 1'b0, 8'd0, 32'h0);
        step();
        chk_out("rd3.e2", 1'b1, 8'd3, 32'hAC0200FF);
        instr_ready = 1'b1;
        step();
        chk_out("rd3.e3", 1'b1, 8'd4, 32'h08000000);

        // Redirect to 255 with ready high: wrap to 0.
        do_reset();
        instr_ready = 1'b1;
        repeat (3) step();
        redirect_valid  = 1'b1;
        redirect_target = 8'd255;
        step();
        redirect_valid = 1'b0;
        step();
        chk_out("wrap.e1", 1'b0, 8'd0, 32'h0);
        step();
        chk_out("wrap.e2", 1'b1, 8'd255, 32'h00000000);
        step();
        chk_out("wrap.e3", 1'b1, 8'd0, 32'h8C0100FF);

        // Asynchronous reset between edges.
        do_reset();
        instr_ready = 1'b1;
        repeat (4) step();
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("async.valid", {31'd0, instr_valid}, 32'd0);
        chk("async.addr", {24'd0, mem_address}, 32'd0);
        chk("async.instr", instr, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        step();
        chk_out("async.e1", 1'b0, 8'd0, 32'h0);
        step();
        chk_out("async.e2", 1'b1, 8'd0, 32'h8C0100FF);

        // Random ready/redirect against an in-order delivery model.
        do_reset();
        exp_pc = 8'd0;
        pops   = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            instr_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid  = ($urandom_range(0, 19) == 0);
            redirect_target = ($urandom_range(0, 1) == 0) ?
                              8'($urandom_range(0, 7)) :
                              8'($urandom_range(0, 255));
            #1;
            pop = instr_valid && instr_ready;
            if (pop) begin
                chk($sformatf("rnd%0d.pc", c), {24'd0, instr_pc},
                    {24'd0, exp_pc});
                chk($sformatf("rnd%0d.instr", c), instr, mem[exp_pc]);
                exp_pc = next_pc(exp_pc);
                pops++;
            end
            if (redirect_valid) exp_pc = redirect_target;
            @(posedge clock);
        end
        chk("rnd.progress", {31'd0, pops >= 100}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Requester side of the instruction memory read interface. Owns the program counter and drives the word address to the synchronous-read instruction memory, which returns the word one clock edge after it samples the address. Tracks the read in flight and buffers returned words in a 2-entry queue. Presents instructions to decode with a valid/ready handshake and accepts PC redirects from the pipeline.

Parameters:
ADDR_WIDTH, 8, word-address width; the PC counts words, +1 per instruction
DATA_WIDTH, 32, instruction width
RESET_PC, 0, PC loaded on reset

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
mem_address  out  ADDR_WIDTH  word address to instruction memory; equals the PC register
mem_q  in  DATA_WIDTH  memory read data for the address sampled at the previous edge
instr_valid  out  1  instr/instr_pc hold a valid instruction
instr_ready  in  1  decode accepts; transfer when instr_valid && instr_ready
instr  out  DATA_WIDTH  instruction word at head of queue
instr_pc  out  ADDR_WIDTH  word address of instr
redirect_valid  in  1  one-cycle request to restart fetch
redirect_target  in  ADDR_WIDTH  new PC

Behaviour:
- Reset (async, active-high):
  - pc = RESET_PC; inflight flag = 0; queue empty.
  - Outputs: instr_valid = 0, instr = 0, instr_pc = 0.
  - Takes effect immediately and wins over every other event, including mid-operation.
- Memory timing:
  - The memory captures mem_address at every edge and cannot stall.
  - The word for address A is on mem_q during the cycle after the edge that sampled A.
  - Re-reading an address is harmless because the memory is read-only.
- Per-edge pop: pop = instr_valid && instr_ready.
- Issue rule: issue = (occupancy + inflight − pop) < 2, with occupancy in 0..2.
  - On issue: inflight <= 1, inflight_pc <= pc, pc <= pc + 1 (mod 2^ADDR_WIDTH, so 255 wraps to 0).
  - No issue: pc holds and inflight <= 0.
- Capture: if inflight = 1 at an edge, {mem_q, inflight_pc} is pushed onto the queue tail. The issue rule guarantees a free slot.
- Output: instr/instr_pc are registered from the queue head. Queue order is strict FIFO.
- Throughput: with instr_ready held high, one instruction per cycle.
- Startup latency: first instr_valid = 1 (pc RESET_PC) after the 2nd rising edge following reset release.
- Backpressure: with instr_ready low, at most 2 words are buffered and the PC stops advancing. No word is dropped or duplicated.
- Redirect (redirect_valid high at an edge):
  - The queue is flushed and inflight is cleared, so the word returning next cycle is discarded.
  - pc <= redirect_target.
  - A pop in the same cycle still counts as delivered.
  - Target instruction becomes valid after the 2nd edge following the redirect edge.
  - Back-to-back redirects: the last one wins.
- Priority: reset > redirect > predecode jump > sequential.
- States:
  - RUN: issuing.
  - HOLD: issue blocked by the credit check.
  - RESTART: the one cycle after a redirect, with nothing in flight.
  - Transitions follow the issue and redirect rules above. State is visible only through mem_address and instr_valid timing.

Optional Feature:
- Macro: JUMP_PREDECODE_EN.
- Defined:
  - Each captured word with bits[31:26] = 6'b000010 (J) acts as an internal redirect to word[ADDR_WIDTH-1:0] at that same edge.
  - The sequential read already in flight is killed, and pc <= target.
  - The J word itself is still enqueued and delivered.
  - An external redirect at the same edge overrides it.
- Undefined: J words pass through like any other instruction, and sequential fetch continues until an external redirect.

Test Plan:
Bench memory holds 0:8C0100FF, 1:AC010009, 2:8C020009, 3:AC0200FF, 4:08000000, and 0 elsewhere. It is sampled at posedge as described above.

1. Reset pulse, then instr_ready = 1 -> instr_valid rises after the 2nd edge. Consecutive cycles deliver pc 0..4 with the words above. Without the macro, pc 5 = 00000000 follows.
2. JUMP_PREDECODE_EN defined, ready = 1 -> after pc 4 (08000000) the next delivered instruction is pc 0 (8C0100FF), with exactly 1 invalid cycle between. pc 5 is never delivered. The loop repeats.
3. ready dropped for 5 cycles while pc 1 is valid -> instr holds AC010009/pc 1 and mem_address advances at most to 3. On release, pc 2 and pc 3 follow back-to-back with none missing or repeated.
4. Queue full (ready low), then redirect_valid with target 3 -> the queue empties and stale words 1/2 never appear. AC0200FF/pc 3 is valid after the 2nd edge following the redirect.
5. Redirect to 255 with ready = 1 -> pc 255 (00000000) is delivered, then pc 0 (8C0100FF): wrap-around.
6. Async reset asserted mid-stream between edges -> instr_valid = 0 and mem_address = 0 immediately, before any edge. After release, the sequence restarts at pc 0 per test 1.
